window_bundler: RTL and testbench

- Temporal bundling stage directly upstream of the class-similarity comparator.
- Accepts one encoded sample hypervector per handshake and keeps a per-dimension population count over a window of WINDOW samples.
- At the end of each window, emits the majority-thresholded window hypervector. That output is the query HV compared against the non-seizure and seizure class HVs.
- Uses a valid/ready handshake on both sides so the encoder and comparator stages can stall independently.

---
 rtl/window_bundler.sv | 163 ++++++++++++++++
 tb/tb_window_bundler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_bundler.sv
// ---------------------------------------------------------------------------
// window_bundler
//
// Temporal bundling stage. It accepts one encoded sample hypervector per
// handshake and keeps a population count per dimension over WINDOW samples.
// When a window completes, it registers the majority-thresholded hypervector
// as the query HV for the downstream class-similarity comparator.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer holding valid keeps its data stable until the transfer.
//   On the output side, out_hv/out_valid hold while out_valid && !out_ready.
//   Only the window-completing sample stalls: in_ready drops when the
//   current window is one sample from completion and the previous result
//   is still pending.
//
// Ports:
//   clk         single clock, rising-edge
//   rst         synchronous active-high reset
//   clear       synchronous abort of the partial window (pending result kept)
//   in_hv       encoded sample hypervector        [DIMENSIONS]
//   in_valid    in_hv is valid
//   in_ready    sample is accepted this cycle (combinational from out_ready)
//   out_hv      bundled window hypervector        [DIMENSIONS]
//   out_valid   out_hv holds an unconsumed window result
//   out_ready   downstream consumes out_hv this cycle
//   sample_cnt  samples accumulated in the current window [CNT_W]
//
// Build option:
//   WINDOW_BUNDLER_TIEBREAK_EN  when defined, a tie (2*total == WINDOW, only
//   possible for even WINDOW) resolves to bit i of the first sample of the
//   window rotated left by one. When undefined, ties resolve to 0.
//
// CNT_W is derived from WINDOW and must not be overridden.
// ---------------------------------------------------------------------------
module window_bundler #(
    parameter int DIMENSIONS = 10000,
    parameter int WINDOW     = 256,
    parameter int CNT_W      = $clog2(WINDOW + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DIMENSIONS-1:0] in_hv,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DIMENSIONS-1:0] out_hv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      sample_cnt
);

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WINDOW - 1);
    // Threshold compared against 2*total, which needs CNT_W+2 bits.
    localparam logic [CNT_W+1:0] THRESH      = (CNT_W + 2)'(WINDOW);

    logic [CNT_W-1:0]      cnt_q [DIMENSIONS];
    logic [CNT_W-1:0]      sample_q;
    logic [DIMENSIONS-1:0] out_hv_q;
    logic                  out_valid_q;

    logic                  last;
    logic                  accept;
    logic                  complete;
    logic [DIMENSIONS-1:0] majority;
    logic [DIMENSIONS-1:0] tie_bits;

    assign last     = (sample_q == LAST_SAMPLE);
    assign in_ready = !(last && out_valid_q && !out_ready);
    // clear wins over accept: the sample offered during clear is dropped.
    assign accept   = in_valid && in_ready && !clear;
    assign complete = accept && last;

`ifdef WINDOW_BUNDLER_TIEBREAK_EN
    logic [DIMENSIONS-1:0] tiebreak_q;
    logic [DIMENSIONS-1:0] rot_hv;

    // Rotate left by one: bit i takes in_hv[(i-1) mod DIMENSIONS].
    always_comb begin
        rot_hv = '0;
        for (int i = 0; i < DIMENSIONS; i++) begin
            rot_hv[i] = in_hv[(i + DIMENSIONS - 1) % DIMENSIONS];
        end
    end

    // Loaded on the first accept of every window, so a cleared window
    // picks up a fresh tiebreak from its new first sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            tiebreak_q <= '0;
        end else if (accept && (sample_q == '0)) begin
            tiebreak_q <= rot_hv;
        end
    end

    assign tie_bits = tiebreak_q;
`else
    assign tie_bits = '0;
`endif

    // Majority per dimension including the sample being accepted now, so
    // the completing sample contributes to the registered result.
    always_comb begin
        logic [CNT_W:0]   total;
        logic [CNT_W+1:0] twice;
        majority = '0;
        total    = '0;
        twice    = '0;
        for (int i = 0; i < DIMENSIONS; i++) begin
            total = {1'b0, cnt_q[i]} + (CNT_W + 1)'(in_hv[i]);
            twice = {total, 1'b0};
            if (twice > THRESH) begin
                majority[i] = 1'b1;
            end else if (twice == THRESH) begin
                majority[i] = tie_bits[i];
            end else begin
                majority[i] = 1'b0;
            end
        end
    end

    // Per-dimension population counters. They clear on the completing
    // sample, so they never need to hold the value WINDOW.
    always_ff @(posedge clk) begin
        if (rst || clear || complete) begin
            for (int i = 0; i < DIMENSIONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < DIMENSIONS; i++) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(in_hv[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear || complete) begin
            sample_q <= '0;
        end else if (accept) begin
            sample_q <= sample_q + CNT_W'(1);
        end
    end

    // Result register: a completing window overwrites even when the
    // previous result is being consumed on the same edge, keeping
    // out_valid high back-to-back. clear does not touch this register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_hv_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (complete) begin
            out_hv_q    <= majority;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_hv     = out_hv_q;
    assign out_valid  = out_valid_q;
    assign sample_cnt = sample_q;

endmodule

// File: tb/tb_window_bundler.sv
// ---------------------------------------------------------------------------
// tb_window_bundler
//
// Four DIMENSIONS=8 instances with WINDOW = 3, 4, 2, 1 (indices 0..3).
// A reference model computes each window's majority when the bench drives
// the completing sample and pushes {index, hv} into exp_q; a monitor on the
// falling edge pops and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_window_bundler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [7:0] in_hv     [4];
    logic       in_valid  [4];
    logic       in_ready  [4];
    logic       clear     [4];
    logic [7:0] out_hv    [4];
    logic       out_valid [4];
    logic       out_ready [4];
    logic [1:0] sc0;
    logic [2:0] sc1;
    logic [1:0] sc2;
    logic [0:0] sc3;

    window_bundler #(.DIMENSIONS(8), .WINDOW(3)) dut_w3 (
        .clk(clk), .rst(rst), .clear(clear[0]), .in_hv(in_hv[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_hv(out_hv[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sample_cnt(sc0)
    );
    window_bundler #(.DIMENSIONS(8), .WINDOW(4)) dut_w4 (
        .clk(clk), .rst(rst), .clear(clear[1]), .in_hv(in_hv[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_hv(out_hv[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sample_cnt(sc1)
    );
    window_bundler #(.DIMENSIONS(8), .WINDOW(2)) dut_w2 (
        .clk(clk), .rst(rst), .clear(clear[2]), .in_hv(in_hv[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .out_hv(out_hv[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sample_cnt(sc2)
    );
    window_bundler #(.DIMENSIONS(8), .WINDOW(1)) dut_w1 (
        .clk(clk), .rst(rst), .clear(clear[3]), .in_hv(in_hv[3]),
        .in_valid(in_valid[3]), .in_ready(in_ready[3]), .out_hv(out_hv[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .sample_cnt(sc3)
    );

    int wins [4] = '{3, 4, 2, 1};

    function automatic int get_sc(int k);
        case (k)
            0:       return int'(sc0);
            1:       return int'(sc1);
            2:       return int'(sc2);
            default: return int'(sc3);
        endcase
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [9:0] exp_q[$];
    int         m_cnt [4][8];
    int         m_n   [4];
    logic [7:0] m_tb  [4];
    bit         rand_bp = 1'b0;

    task automatic model_clear(input int k);
        m_n[k] = 0;
        for (int b = 0; b < 8; b++) m_cnt[k][b] = 0;
    endtask

    task automatic model_reset_all();
        for (int k = 0; k < 4; k++) begin
            model_clear(k);
            m_tb[k] = 8'h00;
        end
    endtask

    task automatic model_accept(input int k, input logic [7:0] hv);
        logic [7:0] res;
        res = 8'h00;
        if (m_n[k] == 0) m_tb[k] = {hv[6:0], hv[7]};
        for (int b = 0; b < 8; b++) m_cnt[k][b] += int'(hv[b]);
        m_n[k]++;
        if (m_n[k] == wins[k]) begin
            for (int b = 0; b < 8; b++) begin
                if (2 * m_cnt[k][b] > wins[k]) begin
                    res[b] = 1'b1;
                end else if (2 * m_cnt[k][b] < wins[k]) begin
                    res[b] = 1'b0;
                end else begin
`ifdef WINDOW_BUNDLER_TIEBREAK_EN
                    res[b] = m_tb[k][b];
`else
                    res[b] = 1'b0;
`endif
                end
            end
            exp_q.push_back({2'(k), res});
            model_clear(k);
        end
    endtask

    // Monitor: one comparison per output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("out_unexpected_%0d", k), exp_q.size(), 1);
                    end else begin
                        logic [9:0] e;
                        e = exp_q.pop_front();
                        check($sformatf("out_hv_%0d", k), {22'b0, 2'(k), out_hv[k]}, {22'b0, e});
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int k, input logic [7:0] hv);
        bit acc;
        int waited;
        acc    = 1'b0;
        waited = 0;
        in_hv[k]    = hv;
        in_valid[k] = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready[k] && !clear[k];
            @(posedge clk);
            #1;
            if (acc) model_accept(k, hv);
            if (rand_bp) out_ready[k] = 1'($urandom_range(0, 1));
            waited++;
            if (!acc && waited > 50) begin
                check("send_timeout", 1, 0);
                break;
            end
        end
        in_valid[k] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] tie_exp;

    initial begin
        for (int k = 0; k < 4; k++) begin
            in_hv[k]     = 8'h00;
            in_valid[k]  = 1'b0;
            clear[k]     = 1'b0;
            out_ready[k] = 1'b1;
        end
        model_reset_all();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_valid_%0d", k), out_valid[k], 0);
            check($sformatf("rst_hv_%0d", k), out_hv[k], 0);
            check($sformatf("rst_sc_%0d", k), get_sc(k), 0);
            check($sformatf("rst_ready_%0d", k), in_ready[k], 1);
        end

        // Basic majority, WINDOW=3
        send(0, 8'hF0);
        check("basic_sc2", get_sc(0), 1);
        send(0, 8'hCC);
        check("basic_pre_valid", out_valid[0], 0);
        send(0, 8'hAA);
        check("basic_valid", out_valid[0], 1);
        check("basic_hv", out_hv[0], 8'hE8);
        check("basic_sc0", get_sc(0), 0);
        @(posedge clk); #1;
        check("basic_drop", out_valid[0], 0);

        // Tie, WINDOW=4
`ifdef WINDOW_BUNDLER_TIEBREAK_EN
        tie_exp = 8'hFF;
`else
        tie_exp = 8'h00;
`endif
        send(1, 8'hFF);
        send(1, 8'hFF);
        send(1, 8'h00);
        send(1, 8'h00);
        check("tie_valid", out_valid[1], 1);
        check("tie_hv", out_hv[1], tie_exp);
        @(posedge clk); #1;

        // Backpressure, WINDOW=2
        out_ready[2] = 1'b0;
        send(2, 8'hF0);
        send(2, 8'hF0);
        check("bp_valid", out_valid[2], 1);
        check("bp_hv", out_hv[2], 8'hF0);
        send(2, 8'h3C);
        check("bp_third_sc", get_sc(2), 1);
        in_hv[2]    = 8'h3C;
        in_valid[2] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("bp_stall", in_ready[2], 0);
            check("bp_hold_hv", out_hv[2], 8'hF0);
            check("bp_hold_valid", out_valid[2], 1);
            check("bp_hold_sc", get_sc(2), 1);
        end
        out_ready[2] = 1'b1;
        #1 check("bp_ready_comb", in_ready[2], 1);
        @(posedge clk); #1;
        model_accept(2, 8'h3C);
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b0;
        check("bp_new_valid", out_valid[2], 1);
        check("bp_new_hv", out_hv[2], 8'h3C);
        check("bp_new_sc", get_sc(2), 0);
        out_ready[2] = 1'b1;
        @(posedge clk); #1;
        check("bp_drain", out_valid[2], 0);

        // clear mid-window, WINDOW=3
        send(0, 8'hFF);
        send(0, 8'hFF);
        check("clr_sc2", get_sc(0), 2);
        clear[0]    = 1'b1;
        in_hv[0]    = 8'hFF;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        clear[0]    = 1'b0;
        in_valid[0] = 1'b0;
        model_clear(0);
        check("clr_sc0", get_sc(0), 0);
        check("clr_no_out", out_valid[0], 0);
        send(0, 8'h00);
        check("clr_sc_a", get_sc(0), 1);
        send(0, 8'h00);
        check("clr_sc_b", get_sc(0), 2);
        send(0, 8'h00);
        check("clr_valid", out_valid[0], 1);
        check("clr_hv", out_hv[0], 8'h00);
        @(posedge clk); #1;

        // Reset with a pending result and a partial window
        out_ready[0] = 1'b0;
        send(0, 8'h0F);
        send(0, 8'h0F);
        send(0, 8'hF0);
        send(0, 8'h11);
        send(0, 8'h22);
        check("mrst_pre_sc", get_sc(0), 2);
        check("mrst_pre_valid", out_valid[0], 1);
        check("mrst_pre_hv", out_hv[0], 8'h0F);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_reset_all();
        check("mrst_valid", out_valid[0], 0);
        check("mrst_hv", out_hv[0], 8'h00);
        check("mrst_sc", get_sc(0), 0);
        check("mrst_ready", in_ready[0], 1);
        out_ready[0] = 1'b1;
        send(0, 8'h81);
        send(0, 8'h81);
        send(0, 8'h18);
        check("mrst_after_hv", out_hv[0], 8'h81);
        @(posedge clk); #1;

        // WINDOW=1 streaming
        send(3, 8'h5A);
        check("w1_valid_a", out_valid[3], 1);
        check("w1_hv_a", out_hv[3], 8'h5A);
        send(3, 8'h3C);
        check("w1_valid_b", out_valid[3], 1);
        check("w1_hv_b", out_hv[3], 8'h3C);
        @(posedge clk); #1;
        check("w1_drop", out_valid[3], 0);

        // Random stream with random backpressure, WINDOW=4 (ties included)
        rand_bp = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send(1, 8'($urandom_range(0, 255)));
        end
        rand_bp = 1'b0;
        out_ready[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
